// File: rtl/axis_icrc_field_mask_pkg.sv
// RoCEv2 ICRC invariant-field definitions: variant field offsets relative to the
// start of the IP header, minimum masked header lengths and the per-byte mask lookup.
package axis_icrc_field_mask_pkg;

    typedef enum logic {
        MODE_IPV4 = 1'b0,
        MODE_IPV6 = 1'b1
    } ip_mode_e;

    localparam int V4_TOS        = 1;
    localparam int V4_TTL        = 8;
    localparam int V4_HDR_CSUM   = 10;   // two bytes
    localparam int V4_UDP_CSUM   = 26;   // two bytes
    localparam int V4_BTH_RESV8A = 32;

    localparam int V6_TC_HI      = 0;    // low nibble of byte 0 only
    localparam int V6_TC_FLOW    = 1;    // three bytes
    localparam int V6_HOP        = 7;
    localparam int V6_UDP_CSUM   = 46;   // two bytes
    localparam int V6_BTH_RESV8A = 52;

    localparam int MIN_HDR_V4    = 33;
    localparam int MIN_HDR_V6    = 53;

    function automatic logic [7:0] mask_byte(input int rel_pos, input logic ipv6);
        logic [7:0] m;
        m = 8'h00;
        if (ipv6) begin
            if (rel_pos == V6_TC_HI)
                m = 8'h0F;
            else if ((rel_pos >= V6_TC_FLOW && rel_pos <= V6_TC_FLOW + 2) ||
                     (rel_pos == V6_HOP) ||
                     (rel_pos == V6_UDP_CSUM) || (rel_pos == V6_UDP_CSUM + 1) ||
                     (rel_pos == V6_BTH_RESV8A))
                m = 8'hFF;
        end else begin
            if ((rel_pos == V4_TOS) || (rel_pos == V4_TTL) ||
                (rel_pos == V4_HDR_CSUM) || (rel_pos == V4_HDR_CSUM + 1) ||
                (rel_pos == V4_UDP_CSUM) || (rel_pos == V4_UDP_CSUM + 1) ||
                (rel_pos == V4_BTH_RESV8A))
                m = 8'hFF;
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_icrc_field_mask_skid.sv
// Two-entry registered buffer (output register + temp register) with registered
// ready; accepts a beat whenever downstream was ready or both entries are empty.
module axis_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i
);

    logic [WIDTH-1:0] out_data_q, tmp_data_q;
    logic             out_vld_q, out_vld_d;
    logic             tmp_vld_q, tmp_vld_d;
    logic             rdy_q, rdy_d;
    logic             in_to_out, in_to_tmp, tmp_to_out;

    always_comb begin
        out_vld_d  = out_vld_q;
        tmp_vld_d  = tmp_vld_q;
        in_to_out  = 1'b0;
        in_to_tmp  = 1'b0;
        tmp_to_out = 1'b0;
        rdy_d      = m_ready_i || (!out_vld_q && !tmp_vld_q);
        // With ready high the temp entry is always empty, so input goes to the
        // output register unless it is held, in which case it parks in temp.
        if (rdy_q) begin
            if (m_ready_i || !out_vld_q) begin
                out_vld_d = s_valid_i;
                in_to_out = 1'b1;
            end else begin
                tmp_vld_d = s_valid_i;
                in_to_tmp = 1'b1;
            end
        end else if (m_ready_i) begin
            out_vld_d  = tmp_vld_q;
            tmp_vld_d  = 1'b0;
            tmp_to_out = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            tmp_vld_q <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            out_vld_q <= out_vld_d;
            tmp_vld_q <= tmp_vld_d;
            rdy_q     <= rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_to_out)
            out_data_q <= s_data_i;
        else if (tmp_to_out)
            out_data_q <= tmp_data_q;
        if (in_to_tmp)
            tmp_data_q <= s_data_i;
    end

    assign s_ready_o = rdy_q;
    assign m_data_o  = out_data_q;
    assign m_valid_o = out_vld_q;

endmodule

// File: rtl/axis_icrc_field_mask.sv
// RoCEv2 ICRC masker: ORs all-ones over the variant IPv4/IPv6/UDP/BTH fields on a
// copy of the stream, forwards the raw data alongside and flags truncated headers.
module axis_icrc_field_mask
    import axis_icrc_field_mask_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int HDR_OFFSET = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    input  logic                    s_axis_ipv6,
    output logic [DATA_WIDTH-1:0]   m_axis_masked_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_masked_tkeep,
    output logic                    m_axis_masked_tvalid,
    output logic                    m_axis_masked_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_masked_tuser,
    input  logic                    m_axis_masked_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_not_masked_tdata,
    output logic                    m_axis_ipv6,
    output logic                    stat_short_pkt
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int BEATS_MAX = (HDR_OFFSET + MIN_HDR_V6 + BYTES - 1) / BYTES;
    localparam int CNT_W     = $clog2(BEATS_MAX + 1);
    localparam int KCNT_W    = $clog2(BYTES) + 1;
    localparam int BCNT_W    = 16;
    localparam int PL_W      = 2 * DATA_WIDTH + BYTES + USER_WIDTH + 2;

    localparam logic [BCNT_W-1:0] BCNT_CAP = BCNT_W'(HDR_OFFSET + MIN_HDR_V6);
    localparam logic [BCNT_W-1:0] MIN_V4   = BCNT_W'(HDR_OFFSET + MIN_HDR_V4);
    localparam logic [BCNT_W-1:0] MIN_V6   = BCNT_W'(HDR_OFFSET + MIN_HDR_V6);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
    ip_mode_e              mode_q, mode_d;
    logic                  short_q, short_d;

    logic                  s_ready;
    logic                  accept;
    logic                  ipv6_eff;
    logic [DATA_WIDTH-1:0] mask;
    logic [KCNT_W-1:0]     kcnt;
    logic [BCNT_W-1:0]     bcnt_step, bcnt_total;
    logic [PL_W-1:0]       s_pl, m_pl;

    assign accept   = s_axis_tvalid && s_ready;
    // The first beat of a packet uses the live mode pin; later beats use the latched one.
    assign ipv6_eff = (cnt_q == '0) ? s_axis_ipv6 : (mode_q == MODE_IPV6);

    always_comb begin
        mask = '0;
        for (int b = 0; b < BYTES; b++)
            mask[b*8 +: 8] = mask_byte(int'(cnt_q) * BYTES + b - HDR_OFFSET, ipv6_eff);
    end

    always_comb begin
        kcnt = '0;
        for (int b = 0; b < BYTES; b++)
            kcnt = kcnt + KCNT_W'(s_axis_tkeep[b]);
    end

    assign bcnt_step  = bcnt_q + BCNT_W'(BYTES);
    assign bcnt_total = bcnt_q + BCNT_W'(kcnt);

    always_comb begin
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        mode_d  = mode_q;
        short_d = 1'b0;
        if (accept) begin
            if (cnt_q == '0)
                mode_d = ipv6_eff ? MODE_IPV6 : MODE_IPV4;
            if (s_axis_tlast) begin
                cnt_d   = '0;
                bcnt_d  = '0;
                short_d = bcnt_total < (ipv6_eff ? MIN_V6 : MIN_V4);
            end else begin
                // Both counters stop once past the last masked byte.
                if (cnt_q != CNT_W'(BEATS_MAX))
                    cnt_d = cnt_q + CNT_W'(1);
                bcnt_d = (bcnt_step >= BCNT_CAP) ? BCNT_CAP : bcnt_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            bcnt_q  <= '0;
            mode_q  <= MODE_IPV4;
            short_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            mode_q  <= mode_d;
            short_q <= short_d;
        end
    end

    assign s_pl = {ipv6_eff, s_axis_tuser, s_axis_tlast, s_axis_tkeep,
                   s_axis_tdata, s_axis_tdata | mask};

    axis_skid_buf #(
        .WIDTH(PL_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_pl),
        .s_valid_i (s_axis_tvalid),
        .s_ready_o (s_ready),
        .m_data_o  (m_pl),
        .m_valid_o (m_axis_masked_tvalid),
        .m_ready_i (m_axis_masked_tready)
    );

    assign {m_axis_ipv6, m_axis_masked_tuser, m_axis_masked_tlast, m_axis_masked_tkeep,
            m_axis_not_masked_tdata, m_axis_masked_tdata} = m_pl;

    assign s_axis_tready  = s_ready;
    assign stat_short_pkt = short_q;

endmodule
